// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the binary32 pipelined multiplier.
// Holds the rounding-mode enum, the status word layout and the IEEE encodings used by the exception mux.
package fp_mult_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IEEE_NEAR = 3'd0,
        IEEE_ZERO = 3'd1,
        IEEE_PINF = 3'd2,
        IEEE_NINF = 3'd3,
        NEAR_UP   = 3'd4,
        AWAY_ZERO = 3'd5
    } rnd_t;

    localparam int unsigned ST_ZERO    = 0;
    localparam int unsigned ST_INF     = 1;
    localparam int unsigned ST_NAN     = 2;
    localparam int unsigned ST_TINY    = 3;
    localparam int unsigned ST_HUGE    = 4;
    localparam int unsigned ST_INEXACT = 5;

    localparam int    EXP_BIAS = 127;
    localparam word_t MAXNORM  = 32'h7F7F_FFFF;
    localparam word_t MINNORM  = 32'h0080_0000;
    localparam word_t QNAN     = 32'h7FC0_0000;
    localparam word_t INF      = 32'h7F80_0000;

    // Field order puts zero at bit 0 so the packed struct matches the status bus directly.
    typedef struct packed {
        logic [1:0] rsvd;
        logic       inexact;
        logic       huge;
        logic       tiny;
        logic       nan;
        logic       inf;
        logic       zero;
    } status_t;

    // True when the mode pushes this sign's magnitude upward (away from zero).
    function automatic logic rounds_away(input rnd_t rnd, input logic sign);
        return (rnd == AWAY_ZERO) || (rnd == IEEE_PINF && !sign) || (rnd == IEEE_NINF && sign);
    endfunction

    function automatic logic is_directed(input rnd_t rnd);
        return (rnd == IEEE_ZERO) || (rnd == IEEE_PINF) || (rnd == IEEE_NINF);
    endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Operation/result bus of the multiplier; the master issues operands, the slave returns results.
interface fp_mult_pipe_if
    import fp_mult_pkg::*;
;
    logic        in_valid;
    word_t       a;
    word_t       b;
    logic [2:0]  rnd;
    logic        out_valid;
    word_t       z;
    logic [7:0]  status;

    modport master (
        output in_valid, a, b, rnd,
        input  out_valid, z, status
    );

    modport slave (
        input  in_valid, a, b, rnd,
        output out_valid, z, status
    );

endinterface

// File: rtl/fp_round.sv
// Combinational rounding of a normalised 23-bit fraction using guard/sticky and the selected mode.
// mant_out[23] is the carry-out; when set the fraction bits are already zero.
module fp_round
    import fp_mult_pkg::*;
(
    input  logic [22:0] man,
    input  logic        guard,
    input  logic        sticky,
    input  logic        sign,
    input  rnd_t        rnd,
    output logic [23:0] mant_out,
    output logic        inexact
);

    logic lost;
    logic up;

    always_comb begin
        lost = guard | sticky;
        up   = 1'b0;
        case (rnd)
            IEEE_ZERO: up = 1'b0;
            IEEE_PINF: up = !sign && lost;
            IEEE_NINF: up = sign && lost;
            NEAR_UP:   up = guard;
            AWAY_ZERO: up = lost;
            // Codes 6 and 7 fall through to ties-to-even.
            default:   up = guard && (sticky || man[0]);
        endcase
        inexact  = lost;
        mant_out = {1'b0, man} + {23'd0, up};
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Two-stage IEEE-754 binary32 multiplier: S1 registers operands, S2 registers the rounded result and status.
// Denormal inputs flush to zero, NaN inputs behave as infinity, and results are never denormal.
module fp_mult_pipe
    import fp_mult_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fp_mult_pipe_if.slave io
);

    // Stage 1 operand registers
    logic  v1;
    word_t a_q;
    word_t b_q;
    rnd_t  rnd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1    <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            rnd_q <= IEEE_NEAR;
        end else begin
            v1    <= io.in_valid;
            a_q   <= io.a;
            b_q   <= io.b;
            rnd_q <= rnd_t'(io.rnd);
        end
    end

    // Operand decode
    logic        sign;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic        a_zero;
    logic        b_zero;
    logic        a_inf;
    logic        b_inf;

    assign sign   = a_q[31] ^ b_q[31];
    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1);
    assign b_inf  = (eb == '1);

    // Significand product and normalisation
    logic [47:0]        prod;
    logic signed [9:0]  exp_sum;
    logic signed [9:0]  exp_norm;
    logic [22:0]        man_n;
    logic               guard_n;
    logic               sticky_n;

    assign prod    = {24'd0, 1'b1, a_q[22:0]} * {24'd0, 1'b1, b_q[22:0]};
    assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'(EXP_BIAS);

    always_comb begin
        if (prod[47]) begin
            man_n    = prod[46:24];
            guard_n  = prod[23];
            sticky_n = |prod[22:0];
        end else begin
            man_n    = prod[45:23];
            guard_n  = prod[22];
            sticky_n = |prod[21:0];
        end
        exp_norm = exp_sum + $signed({9'd0, prod[47]});
    end

    logic [23:0]       mant_r;
    logic              inexact_r;
    logic signed [9:0] exp_post;

    fp_round u_round (
        .man      (man_n),
        .guard    (guard_n),
        .sticky   (sticky_n),
        .sign     (sign),
        .rnd      (rnd_q),
        .mant_out (mant_r),
        .inexact  (inexact_r)
    );

    assign exp_post = exp_norm + $signed({9'd0, mant_r[23]});

    // Exception mux: special operands first, then range checks on the rounded exponent
    logic    ovf;
    logic    unf;
    logic    ovf_to_inf;
    logic    unf_to_min;
    word_t   z_d;
    status_t st_d;

    assign ovf        = (exp_post >= 10'sd255);
    assign unf        = (exp_post <= 10'sd0);
    assign ovf_to_inf = !is_directed(rnd_q) || rounds_away(rnd_q, sign);
    assign unf_to_min = rounds_away(rnd_q, sign);

    always_comb begin
        st_d         = '0;
        st_d.inexact = inexact_r;
        z_d          = {sign, exp_post[7:0], mant_r[22:0]};
        if ((a_zero && b_inf) || (a_inf && b_zero)) begin
            st_d     = '0;
            st_d.nan = 1'b1;
            z_d      = QNAN;
        end else if (a_inf || b_inf) begin
            st_d     = '0;
            st_d.inf = 1'b1;
            z_d      = {sign, INF[30:0]};
        end else if (a_zero || b_zero) begin
            st_d      = '0;
            st_d.zero = 1'b1;
            z_d       = {sign, 31'd0};
        end else if (ovf) begin
            st_d.huge    = 1'b1;
            st_d.inexact = 1'b1;
            if (ovf_to_inf) begin
                st_d.inf = 1'b1;
                z_d      = {sign, INF[30:0]};
            end else begin
                z_d      = {sign, MAXNORM[30:0]};
            end
        end else if (unf) begin
            st_d.tiny    = 1'b1;
            st_d.inexact = 1'b1;
            if (unf_to_min) begin
                z_d       = {sign, MINNORM[30:0]};
            end else begin
                st_d.zero = 1'b1;
                z_d       = {sign, 31'd0};
            end
        end
    end

    // Stage 2 result registers
    logic    v2;
    word_t   z_q;
    status_t st_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2   <= 1'b0;
            z_q  <= '0;
            st_q <= '0;
        end else begin
            v2   <= v1;
            z_q  <= z_d;
            st_q <= st_d;
        end
    end

    assign io.out_valid = v2;
    assign io.z         = z_q;
    assign io.status    = st_q;

    // Status invariants relied on by downstream monitors
    a_rsvd:     assert property (@(posedge clk) disable iff (!rst) st_q.rsvd == 2'b00);
    a_nan_solo: assert property (@(posedge clk) disable iff (!rst)
                    !(st_q[ST_NAN] && (st_q[ST_ZERO] || st_q[ST_INEXACT] || st_q[ST_HUGE] || st_q[ST_TINY])));
    a_zero_inf: assert property (@(posedge clk) disable iff (!rst) !(st_q[ST_ZERO] && st_q[ST_INF]));
    a_huge_tiny: assert property (@(posedge clk) disable iff (!rst) !(st_q[ST_HUGE] && st_q[ST_TINY]));
    a_zero_exp: assert property (@(posedge clk) disable iff (!rst) !st_q[ST_ZERO] || z_q[30:23] == 8'h00);
    a_inf_exp:  assert property (@(posedge clk) disable iff (!rst) !st_q[ST_INF] || z_q[30:23] == 8'hFF);

endmodule
